// File: rtl/logicnet_input_quantizer.sv
// logicnet_input_quantizer
// Quantizes raw unsigned features, one per beat, to 2-bit codes using three
// fixed thresholds. It packs NUM_FEATURES codes into one vector for the
// layer0 neuron LUTs.
// An assembly register collects the codes of the next sample while the output
// register holds the previous vector, so one sample can load while another waits.
//
// State table:
//   state | meaning
//   FILL  | accepting feature beats into the assembly register
//   HOLD  | assembly register holds a complete vector waiting for the output
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   s_valid/s_ready     raw feature stream handshake
//   s_data              raw unsigned feature
//   s_last              final feature of a sample
//   m_valid/m_ready     packed vector handshake
//   m_data              packed codes, feature i at [2i+1:2i]
//   err_len             one-cycle pulse when a sample is discarded
//   sample_cnt          vectors handed off, wraps
module logicnet_input_quantizer #(
   parameter int NUM_FEATURES = 3,
   parameter int FEAT_W       = 8,
   parameter int THR0         = 64,
   parameter int THR1         = 128,
   parameter int THR2         = 192,
   parameter int CNT_W        = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [FEAT_W-1:0]         s_data,
   input  logic                      s_last,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [2*NUM_FEATURES-1:0] m_data,
   output logic                      err_len,
   output logic [CNT_W-1:0]          sample_cnt
);

   localparam int IDX_W = $clog2(NUM_FEATURES);
   localparam int VEC_W = 2 * NUM_FEATURES;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [VEC_W-1:0]   asm_q, asm_d;
   logic [VEC_W-1:0]   m_data_q, m_data_d;
   logic               m_valid_q, m_valid_d;
   logic               err_len_q, err_len_d;
   logic               drop_q, drop_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic [1:0] code;
   logic       accept;
   logic       at_last_idx;
   logic       out_free;
   logic       consume;

   // An exact threshold hit counts as reaching it, so it rounds up.
   always_comb begin
      code = 2'(s_data >= FEAT_W'(THR0))
           + 2'(s_data >= FEAT_W'(THR1))
           + 2'(s_data >= FEAT_W'(THR2));
   end

   assign accept      = s_valid && (state_q == FILL);
   assign at_last_idx = (idx_q == IDX_W'(NUM_FEATURES - 1));
   assign consume     = m_valid_q && m_ready;
   // The output register can take a new vector when it is empty or is
   // handed off in this cycle.
   assign out_free    = !m_valid_q || m_ready;

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      asm_d     = asm_q;
      m_data_d  = m_data_q;
      m_valid_d = m_valid_q && !consume;
      err_len_d = 1'b0;
      drop_d    = drop_q;
      cnt_d     = cnt_q + CNT_W'(consume);

      case (state_q)
         FILL: begin
            if (accept) begin
               if (drop_q) begin
                  // A long sample overran. Discard its remaining beats up to
                  // its s_last.
                  if (s_last) drop_d = 1'b0;
               end else if (s_last != at_last_idx) begin
                  idx_d     = '0;
                  asm_d     = '0;
                  err_len_d = 1'b1;
                  drop_d    = !s_last;
               end else begin
                  for (int i = 0; i < NUM_FEATURES; i++) begin
                     if (idx_q == IDX_W'(i)) asm_d[2*i +: 2] = code;
                  end
                  if (at_last_idx) begin
                     idx_d = '0;
                     if (out_free) begin
                        m_data_d  = asm_d;
                        m_valid_d = 1'b1;
                     end else begin
                        state_d = HOLD;
                     end
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
         end
         HOLD: begin
            if (out_free) begin
               m_data_d  = asm_q;
               m_valid_d = 1'b1;
               state_d   = FILL;
            end
         end
         default: state_d = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         idx_q     <= '0;
         asm_q     <= '0;
         m_data_q  <= '0;
         m_valid_q <= 1'b0;
         err_len_q <= 1'b0;
         drop_q    <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         asm_q     <= asm_d;
         m_data_q  <= m_data_d;
         m_valid_q <= m_valid_d;
         err_len_q <= err_len_d;
         drop_q    <= drop_d;
         cnt_q     <= cnt_d;
      end
   end

   assign s_ready    = (state_q == FILL);
   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign err_len    = err_len_q;
   assign sample_cnt = cnt_q;

endmodule

// File: tb/tb_logicnet_input_quantizer.sv
// Directed bench for logicnet_input_quantizer with default parameters.
// Inputs change 1 ns after the rising edge. Outputs are checked at that
// same point, so each check sees the registered result of the edge just taken.
module tb_logicnet_input_quantizer;

   logic        clk = 1'b0;
   logic        rst;
   logic        s_valid;
   logic        s_ready;
   logic [7:0]  s_data;
   logic        s_last;
   logic        m_valid;
   logic        m_ready;
   logic [5:0]  m_data;
   logic        err_len;
   logic [15:0] sample_cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   logicnet_input_quantizer dut (
      .clk        (clk),
      .rst        (rst),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_data     (s_data),
      .s_last     (s_last),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data),
      .err_len    (err_len),
      .sample_cnt (sample_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      tick();
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   // Continuous stream of four samples: data, last flag, expected vector.
   logic [7:0] tp_data [12] = '{0, 0, 0, 255, 0, 0, 0, 100, 0, 200, 150, 70};
   logic [5:0] tp_vec  [4]  = '{6'h00, 6'h03, 6'h04, 6'h1B};

   initial begin
      rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
      tick(); tick();
      chk("rst_s_ready", s_ready, 1);
      chk("rst_m_valid", m_valid, 0);
      chk("rst_m_data", m_data, 0);
      chk("rst_err_len", err_len, 0);
      chk("rst_cnt", sample_cnt, 0);
      rst = 1'b0;

      // Basic quantize/pack.
      m_ready = 1'b1;
      send(8'd10, 0);
      chk("basic_no_valid_early", m_valid, 0);
      send(8'd130, 0);
      send(8'd255, 1);
      chk("basic_valid", m_valid, 1);
      chk("basic_data", m_data, 6'h38);
      tick();
      chk("basic_cnt", sample_cnt, 1);
      chk("basic_valid_drop", m_valid, 0);
      chk("basic_data_kept", m_data, 6'h38);

      // Threshold edges.
      send(8'd63, 0); send(8'd64, 0); send(8'd192, 1);
      chk("edge_a_data", m_data, 6'h34);
      tick();
      send(8'd127, 0); send(8'd128, 0); send(8'd191, 1);
      chk("edge_b_data", m_data, 6'h29);
      tick();
      chk("edge_cnt", sample_cnt, 3);

      // Backpressure into HOLD.
      m_ready = 1'b0;
      send(8'd0, 0); send(8'd64, 0); send(8'd128, 1);
      chk("bp_a_valid", m_valid, 1);
      chk("bp_a_data", m_data, 6'h24);
      send(8'd255, 0); send(8'd255, 0); send(8'd255, 1);
      chk("bp_hold_s_ready", s_ready, 0);
      chk("bp_hold_data", m_data, 6'h24);
      tick();
      chk("bp_hold_s_ready2", s_ready, 0);
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_data2", m_data, 6'h24);
      m_ready = 1'b1;
      tick();
      chk("bp_b_data", m_data, 6'h3F);
      chk("bp_b_valid", m_valid, 1);
      chk("bp_s_ready", s_ready, 1);
      chk("bp_cnt_a", sample_cnt, 4);
      tick();
      chk("bp_cnt_b", sample_cnt, 5);
      chk("bp_valid_drop", m_valid, 0);

      // Full throughput, four back-to-back samples.
      for (int i = 0; i < 12; i++) begin
         s_valid = 1'b1;
         s_data  = tp_data[i];
         s_last  = ((i % 3) == 2);
         tick();
         chk("tp_s_ready", s_ready, 1);
         chk("tp_valid", m_valid, ((i % 3) == 2));
         if ((i % 3) == 2) chk("tp_data", m_data, tp_vec[i / 3]);
      end
      s_valid = 1'b0; s_last = 1'b0;
      tick();
      chk("tp_cnt", sample_cnt, 9);

      // Length errors: short sample, then long sample with drop.
      send(8'd50, 0);
      chk("short_no_err_yet", err_len, 0);
      send(8'd50, 1);
      chk("short_err", err_len, 1);
      chk("short_no_valid", m_valid, 0);
      send(8'd10, 0);
      chk("short_err_pulse", err_len, 0);
      send(8'd10, 0);
      send(8'd10, 0);
      chk("long_err", err_len, 1);
      send(8'd200, 1);
      chk("long_drop_no_err", err_len, 0);
      chk("long_drop_no_valid", m_valid, 0);
      chk("long_drop_s_ready", s_ready, 1);
      send(8'd70, 0); send(8'd140, 0); send(8'd200, 1);
      chk("after_err_valid", m_valid, 1);
      chk("after_err_data", m_data, 6'h39);
      tick();
      chk("after_err_cnt", sample_cnt, 10);

      // Reset while in HOLD.
      m_ready = 1'b0;
      send(8'd255, 0); send(8'd255, 0); send(8'd255, 1);
      send(8'd128, 0); send(8'd128, 0); send(8'd128, 1);
      chk("rh_hold", s_ready, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rh_m_valid", m_valid, 0);
      chk("rh_s_ready", s_ready, 1);
      chk("rh_cnt", sample_cnt, 0);
      chk("rh_m_data", m_data, 0);
      m_ready = 1'b1;
      send(8'd0, 0); send(8'd0, 0); send(8'd0, 1);
      chk("rh_zero_valid", m_valid, 1);
      chk("rh_zero_data", m_data, 0);
      tick();
      chk("rh_cnt_after", sample_cnt, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
